bldc_axil_regs: RTL

AXI4-Lite slave register bank for the BLDC motor controller IP: the responder end of the S00_AXI port that the block-design master drives. It holds four 32-bit read/write control registers, applies byte strobes, returns OKAY responses, and exports the register contents plus per-register write pulses to the motor-control core. Address and data paths are independent, with one write FSM and one read FSM.

---
 rtl/bldc_axil_pkg.sv | 32 +++
 rtl/bldc_axil_regs_if.sv | 37 +++
 rtl/bldc_axil_regs.sv | 110 +++++++++++
 3 files changed

// File: rtl/bldc_axil_pkg.sv
// Shared definitions for the BLDC controller AXI4-Lite register bank:
// register map, response codes, FSM state types and the byte-strobe merge.
package bldc_axil_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 4;

  localparam logic [ADDR_W-1:0] REG0 = 4'h0;
  localparam logic [ADDR_W-1:0] REG1 = 4'h4;
  localparam logic [ADDR_W-1:0] REG2 = 4'h8;
  localparam logic [ADDR_W-1:0] REG3 = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Replace only the bytes of cur whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bldc_axil_regs_if.sv
// AXI4-Lite bus bundle between the block-design master and the register bank.
interface bldc_axil_regs_if;
  import bldc_axil_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/bldc_axil_regs.sv
// AXI4-Lite slave with four read/write control registers for the BLDC core.
// Independent write and read FSMs; exports register contents and write pulses.
module bldc_axil_regs
  import bldc_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  bldc_axil_regs_if.slave               s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);

  w_state_t          w_q, w_d;
  r_state_t          r_q, r_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_hs;
  logic              rd_hs;
  logic [1:0]        wsel;
  logic [1:0]        rsel;

  assign wsel = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rsel = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Byte-lane address bits and protection attributes carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    w_d     = w_q;
    wr_hs   = 1'b0;
    regs_d  = regs_q;
    pulse_d = '0;
    unique case (w_q)
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          wr_hs         = 1'b1;
          regs_d[wsel]  = strb_merge(regs_q[wsel], s_axi.wdata, s_axi.wstrb);
          pulse_d[wsel] = |s_axi.wstrb;
          w_d           = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_d     = r_q;
    rd_hs   = 1'b0;
    rdata_d = rdata_q;
    unique case (r_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          rd_hs   = 1'b1;
          // regs_q is the pre-write value when a write lands on the same edge.
          rdata_d = regs_q[rsel];
          r_d     = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) r_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_q     <= W_IDLE;
      r_q     <= R_IDLE;
      pulse_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_q     <= w_d;
      r_q     <= r_d;
      pulse_q <= pulse_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.bvalid  = (w_q == W_RESP);
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = (r_q == R_IDLE);
  assign s_axi.rvalid  = (r_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign slv_reg0     = regs_q[0];
  assign slv_reg1     = regs_q[1];
  assign slv_reg2     = regs_q[2];
  assign slv_reg3     = regs_q[3];
  assign reg_wr_pulse = pulse_q;

  logic unused_hs;
  assign unused_hs = rd_hs;

endmodule
